// File: rtl/mc_register_bank_pkg.sv
// Shared definitions for the MCOI register bank: register array type, bank address map
// and the byte-lane mask helper.
package MCPkg;

   localparam int unsigned MAX_REGS    = 64;
   localparam int unsigned WORD_BITS   = 32;
   localparam int unsigned LANES       = WORD_BITS / 8;
   localparam int unsigned ADDR_LSB    = 2;
   localparam int unsigned CTRL_BASE_W = 0;
   localparam int unsigned STAT_BASE_W = 64;

   typedef logic [MAX_REGS-1:0][WORD_BITS-1:0] regarray_t;

   // Expand per-byte write enables into a per-bit mask.
   function automatic logic [WORD_BITS-1:0] lane_mask(input logic [LANES-1:0] we);
      logic [WORD_BITS-1:0] mask;
      mask = '0;
      for (int b = 0; b < int'(LANES); b++) begin
         mask[8*b +: 8] = {8{we[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/mc_w1c_sticky.sv
// One 32-bit sticky status word: bits latch when set, clear on byte-enabled write-1-to-clear.
// A set in the same cycle as its clear wins, so no event is ever lost.
module mc_w1c_sticky
   import MCPkg::*;
#(
   parameter logic [31:0] STICKY_MASK = '0
) (
   input  logic        Clk_ik,
   input  logic        Rst_irn,
   input  logic [31:0] set_ib,
   input  logic [31:0] clr_ib,
   input  logic [3:0]  be_ib,
   output logic [31:0] sticky_ob
);

   logic [31:0] sticky_d, sticky_q;
   logic [31:0] clr_mask;

   always_comb begin
      clr_mask = clr_ib & lane_mask(be_ib);
      sticky_d = ((sticky_q & ~clr_mask) | set_ib) & STICKY_MASK;
   end

   always_ff @(posedge Clk_ik or negedge Rst_irn) begin
      if (!Rst_irn) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_ob = sticky_q;

endmodule

// File: rtl/mc_register_bank.sv
// Parametrised control/status register bank behind a BRAM-style port: byte-lane control writes,
// self-clearing pulse bits, sticky W1C status bits, read-first data and invalid-access flagging.
module mc_register_bank
   import MCPkg::*;
#(
   parameter int unsigned NUM_CTRL    = 8,
   parameter int unsigned NUM_STAT    = 8,
   parameter int unsigned STAT_BASE   = STAT_BASE_W,
   parameter regarray_t   CTRL_RESET  = '0,
   parameter regarray_t   PULSE_MASK  = '0,
   parameter regarray_t   STICKY_MASK = '0
) (
   input  logic                           Clk_ik,
   input  logic                           Rst_irn,
   input  logic                           en_i,
   input  logic [31:0]                    addr_ib,
   input  logic [31:0]                    din_ib,
   input  logic [3:0]                     we_ib,
   output logic [31:0]                    dout_ob,
   output logic [NUM_CTRL-1:0][31:0]      control_ob,
   output logic [NUM_CTRL-1:0]            ctrl_wr_ob,
   input  logic [NUM_STAT-1:0][31:0]      status_ib,
   output logic                           bad_access_o
);

   logic [29:0]                 word_idx;
   logic                        ctrl_hit, stat_hit, wr_req;
   logic [31:0]                 wr_mask;
   logic [NUM_CTRL-1:0]         ctrl_sel;
   logic [NUM_STAT-1:0]         stat_sel;
   logic [NUM_STAT-1:0][31:0]   stat_word;
   logic [NUM_STAT-1:0][31:0]   stat_clr;
   logic [NUM_STAT-1:0][31:0]   sticky;
   logic [31:0]                 rdata;

   logic [NUM_CTRL-1:0][31:0]   ctrl_d, ctrl_q;
   logic [NUM_CTRL-1:0]         ctrl_wr_d, ctrl_wr_q;
   logic [31:0]                 dout_d, dout_q;
   logic                        bad_d, bad_q;

   logic                        unused_addr_lsb;
   assign unused_addr_lsb = ^addr_ib[ADDR_LSB-1:0];

   assign word_idx = addr_ib[31:ADDR_LSB];
   assign ctrl_hit = (word_idx >= 30'(CTRL_BASE_W)) && (word_idx < 30'(CTRL_BASE_W + NUM_CTRL));
   assign stat_hit = (word_idx >= 30'(STAT_BASE)) && (word_idx < 30'(STAT_BASE + NUM_STAT));
   assign wr_req   = en_i && (we_ib != '0);
   assign wr_mask  = lane_mask(we_ib);

   // Address decode into one-hot word selects.
   always_comb begin
      ctrl_sel = '0;
      stat_sel = '0;
      for (int i = 0; i < int'(NUM_CTRL); i++) begin
         ctrl_sel[i] = ctrl_hit && (word_idx == 30'(CTRL_BASE_W + i));
      end
      for (int j = 0; j < int'(NUM_STAT); j++) begin
         stat_sel[j] = stat_hit && (word_idx == 30'(STAT_BASE + j));
      end
   end

   // Status view and W1C vectors per status word.
   always_comb begin
      stat_word = '0;
      stat_clr  = '0;
      for (int j = 0; j < int'(NUM_STAT); j++) begin
         stat_word[j] = (status_ib[j] & ~STICKY_MASK[j]) | sticky[j];
         stat_clr[j]  = (wr_req && stat_sel[j]) ? din_ib : 32'h0;
      end
   end

   for (genvar g = 0; g < int'(NUM_STAT); g++) begin : g_sticky
      mc_w1c_sticky #(
         .STICKY_MASK (STICKY_MASK[g])
      ) u_sticky (
         .Clk_ik    (Clk_ik),
         .Rst_irn   (Rst_irn),
         .set_ib    (status_ib[g]),
         .clr_ib    (stat_clr[g]),
         .be_ib     (we_ib),
         .sticky_ob (sticky[g])
      );
   end

   // Pulse bits drop every cycle; a write in this cycle re-arms them for one more cycle.
   always_comb begin
      ctrl_d    = '0;
      ctrl_wr_d = '0;
      for (int i = 0; i < int'(NUM_CTRL); i++) begin
         ctrl_d[i] = ctrl_q[i] & ~PULSE_MASK[i];
         if (wr_req && ctrl_sel[i]) begin
            ctrl_d[i] = (ctrl_d[i] & ~wr_mask) | (din_ib & wr_mask);
         end
         ctrl_wr_d[i] = wr_req && ctrl_sel[i];
      end
   end

   // Read mux uses pre-write state; unmapped words read as zero.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(NUM_CTRL); i++) begin
         if (ctrl_sel[i]) begin
            rdata = rdata | (ctrl_q[i] & ~PULSE_MASK[i]);
         end
      end
      for (int j = 0; j < int'(NUM_STAT); j++) begin
         if (stat_sel[j]) begin
            rdata = rdata | stat_word[j];
         end
      end
      dout_d = en_i ? rdata : dout_q;
      bad_d  = en_i && !ctrl_hit && !stat_hit;
   end

   always_ff @(posedge Clk_ik or negedge Rst_irn) begin
      if (!Rst_irn) begin
         for (int i = 0; i < int'(NUM_CTRL); i++) begin
            ctrl_q[i] <= CTRL_RESET[i];
         end
         ctrl_wr_q <= '0;
         dout_q    <= '0;
         bad_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         ctrl_wr_q <= ctrl_wr_d;
         dout_q    <= dout_d;
         bad_q     <= bad_d;
      end
   end

   assign control_ob   = ctrl_q;
   assign ctrl_wr_ob   = ctrl_wr_q;
   assign dout_ob      = dout_q;
   assign bad_access_o = bad_q;

endmodule

// File: tb/tb_mc_register_bank.sv
// Self-checking bench for mc_register_bank: vector table with a scoreboard queue, plus
// hand-written pulse, sticky/W1C and mid-operation reset sequences.
module tb_mc_register_bank;
   import MCPkg::*;

   function automatic regarray_t one_word(input int idx, input logic [31:0] val);
      regarray_t r;
      r = '0;
      r[idx] = val;
      return r;
   endfunction

   localparam regarray_t TB_CTRL_RESET  = one_word(2, 32'hA5A5_0000);
   localparam regarray_t TB_PULSE_MASK  = one_word(0, 32'h0000_0001);
   localparam regarray_t TB_STICKY_MASK = one_word(1, 32'h0000_00FF);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic [31:0]      addr = '0;
   logic [31:0]      din = '0;
   logic [3:0]       we = '0;
   logic [31:0]      dout;
   logic [7:0][31:0] control;
   logic [7:0]       ctrl_wr;
   logic [7:0][31:0] status = '0;
   logic             bad;

   int checks = 0;
   int errors = 0;

   mc_register_bank #(
      .NUM_CTRL    (8),
      .NUM_STAT    (8),
      .STAT_BASE   (64),
      .CTRL_RESET  (TB_CTRL_RESET),
      .PULSE_MASK  (TB_PULSE_MASK),
      .STICKY_MASK (TB_STICKY_MASK)
   ) dut (
      .Clk_ik       (clk),
      .Rst_irn      (rst_n),
      .en_i         (en),
      .addr_ib      (addr),
      .din_ib       (din),
      .we_ib        (we),
      .dout_ob      (dout),
      .control_ob   (control),
      .ctrl_wr_ob   (ctrl_wr),
      .status_ib    (status),
      .bad_access_o (bad)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic [31:0] din;
      logic [3:0]  we;
      logic [31:0] stat0;
      logic [31:0] exp_dout;
      logic        exp_bad;
      logic [7:0]  exp_wr;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] dout;
      logic        bad;
      logic [7:0]  wr;
   } exp_t;

   vec_t        vecs[14];
   exp_t        sb[$];
   logic [31:0] exp_ctrl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w);
      @(negedge clk);
      en   = e;
      addr = a;
      din  = d;
      we   = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ctrl2", control[2], 32'hA5A5_0000);
      chk("reset_ctrl0", control[0], 32'h0);
      chk("reset_dout", dout, 32'h0);
      chk("reset_ctrl_wr", {24'h0, ctrl_wr}, 32'h0);
      chk("reset_bad", {31'h0, bad}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //            en    addr          din            we       stat0          dout           bad   wr
      vecs[0]  = '{1'b1, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         32'hA5A5_0000, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, 32'h0,         32'hA5A5_0000, 1'b0, 8'h04};
      vecs[2]  = '{1'b1, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         32'hA5A5_5678, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 8'h00};
      vecs[4]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 32'h0,         32'h0,         1'b1, 8'h00};
      vecs[5]  = '{1'b1, 32'h0000_000C, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 8'h00};
      vecs[6]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'b1111, 32'h0,         32'h0,         1'b0, 8'h08};
      vecs[7]  = '{1'b1, 32'h0000_000C, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 8'h00};
      vecs[8]  = '{1'b1, 32'h0000_0010, 32'hCAFE_BABE, 4'b1100, 32'h0,         32'h0,         1'b0, 8'h10};
      vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0,         4'b0000, 32'h0,         32'hCAFE_0000, 1'b0, 8'h00};
      vecs[10] = '{1'b1, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 8'h00};
      vecs[11] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b1111, 32'h1111_2222, 32'h1111_2222, 1'b0, 8'h00};
      vecs[12] = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         32'h1111_2222, 1'b0, 8'h00};
      vecs[13] = '{1'b1, 32'h0000_0120, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 8'h00};

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].en, vecs[i].addr, vecs[i].din, vecs[i].we);
         status[0] = vecs[i].stat0;
         sb.push_back('{idx: i, dout: vecs[i].exp_dout, bad: vecs[i].exp_bad, wr: vecs[i].exp_wr});
         tick();
         e = sb.pop_front();
         chk($sformatf("vec%0d_dout", e.idx), dout, e.dout);
         chk($sformatf("vec%0d_bad", e.idx), {31'h0, bad}, {31'h0, e.bad});
         chk($sformatf("vec%0d_ctrl_wr", e.idx), {24'h0, ctrl_wr}, {24'h0, e.wr});
      end
      drive(1'b0, 32'h0, 32'h0, 4'b0000);
      status[0] = '0;
      tick();

      // Control contents after the table; the unmapped write must not have landed anywhere.
      exp_ctrl = '{32'h0, 32'h0, 32'hA5A5_5678, 32'hFFFF_FFFF, 32'hCAFE_0000, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ctrl%0d_final", i), control[i], exp_ctrl[i]);
      end

      // Pulse bit 0 of word 0 alongside an ordinary bit 1.
      drive(1'b1, 32'h0000_0000, 32'h0000_0003, 4'b0001);
      tick();
      chk("pulse_high", control[0], 32'h0000_0003);
      chk("pulse_wr", {24'h0, ctrl_wr}, 32'h0000_0001);
      drive(1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      chk("pulse_low", control[0], 32'h0000_0002);
      chk("pulse_wr_low", {24'h0, ctrl_wr}, 32'h0);
      drive(1'b1, 32'h0000_0000, 32'h0, 4'b0000);
      tick();
      chk("pulse_readback", dout, 32'h0000_0002);

      // Sticky capture on status word 1 (word index 65).
      drive(1'b0, 32'h0, 32'h0, 4'b0000);
      status[1] = 32'h0000_0001;
      tick();
      drive(1'b1, 32'h0000_0104, 32'h0, 4'b0000);
      status[1] = 32'h0;
      tick();
      chk("sticky_read", dout, 32'h0000_0001);
      drive(1'b1, 32'h0000_0104, 32'h0000_0001, 4'b0001);
      tick();
      chk("w1c_read_first", dout, 32'h0000_0001);
      drive(1'b1, 32'h0000_0104, 32'h0, 4'b0000);
      tick();
      chk("w1c_cleared", dout, 32'h0);
      drive(1'b1, 32'h0000_0104, 32'h0000_0001, 4'b0001);
      status[1] = 32'h0000_0001;
      tick();
      chk("collision_read", dout, 32'h0);
      drive(1'b1, 32'h0000_0104, 32'h0, 4'b0000);
      status[1] = 32'h0000_0100;
      tick();
      chk("collision_kept", dout, 32'h0000_0101);
      status[1] = 32'h0;

      // Reset mid-operation drops the pending strobe and clears everything.
      drive(1'b1, 32'h0000_0008, 32'h0, 4'b1111);
      tick();
      chk("pre_reset_wr", {24'h0, ctrl_wr}, 32'h0000_0004);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_ctrl2", control[2], 32'hA5A5_0000);
      chk("midreset_ctrl3", control[3], 32'h0);
      chk("midreset_wr", {24'h0, ctrl_wr}, 32'h0);
      chk("midreset_dout", dout, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h0000_0104, 32'h0, 4'b0000);
      tick();
      chk("post_reset_sticky", dout, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 4'b0000);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
